// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: round-robin grant, registered operands,
// one-cycle execute, and a tagged valid/ready response channel.
module alu_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_pc,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic [4:0]       req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_pc,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    input  logic [4:0]       req1_shamt,
    output logic [WIDTH-1:0] alu_pc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_c,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_nxt;
    logic   rr_ptr;
    logic   owner;
    logic   can_grant;
    logic   gnt_any;
    logic   gnt_id;

    always_comb begin
        can_grant  = 1'b0;
        gnt_any    = 1'b0;
        gnt_id     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        state_nxt  = state;

        // RESP with rsp_ready behaves like IDLE so a new op can start on the same edge
        can_grant  = (state == IDLE) || ((state == RESP) && rsp_ready);
        gnt_any    = can_grant && (req0_valid || req1_valid);
        gnt_id     = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        req0_ready = gnt_any && !gnt_id;
        req1_ready = gnt_any && gnt_id;

        case (state)
            IDLE:    if (gnt_any) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = gnt_any ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            alu_pc    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_shamt <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_c     <= '0;
            rsp_zero  <= 1'b0;
        end else begin
            if (gnt_any) begin
                owner     <= gnt_id;
                rr_ptr    <= ~gnt_id;
                alu_pc    <= gnt_id ? req1_pc    : req0_pc;
                alu_a     <= gnt_id ? req1_a     : req0_a;
                alu_b     <= gnt_id ? req1_b     : req0_b;
                alu_op    <= gnt_id ? req1_op    : req0_op;
                alu_shamt <= gnt_id ? req1_shamt : req0_shamt;
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= owner;
                rsp_c     <= alu_c;
                rsp_zero  <= alu_zero;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequences one shared ALU between two requesters, e.g. the main execute path (port 0) and an auxiliary address/branch unit (port 1).
- Round-robin arbitration; operands registered before the ALU; result and zero flag registered after it.
- One response channel tagged with the requester id and a valid/ready handshake.
- Sits between the requesters and the single ALU instance, which is driven only from this block's alu_* outputs.

Parameters:
WIDTH, 32, data width of PC, A, B and C
OPW, 3, width of the ALU operation code

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_pc  in  WIDTH  PC operand, requester 0
req0_a  in  WIDTH  A operand, requester 0
req0_b  in  WIDTH  B operand, requester 0
req0_op  in  OPW  ALU op, requester 0
req0_shamt  in  5  shift amount, requester 0
req1_valid, req1_ready, req1_pc, req1_a, req1_b, req1_op, req1_shamt  same as req0_*, requester 1
alu_pc / alu_a / alu_b  out  WIDTH  to shared ALU
alu_op  out  OPW  to shared ALU
alu_shamt  out  5  to shared ALU
alu_c  in  WIDTH  ALU result
alu_zero  in  1  ALU equality flag
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester that owns the response
rsp_c  out  WIDTH  registered ALU result
rsp_zero  out  1  registered zero flag

Behaviour:
- Reset (reset=0, asynchronous) clears everything to zero:
  - state=IDLE, rr_ptr=0 (requester 0 has priority);
  - rsp_valid, rsp_id, rsp_c, rsp_zero = 0;
  - alu_* registers = 0.
- Any in-flight operation is discarded; no response is produced for it.
- A grant is possible when state=IDLE, or when state=RESP with rsp_ready=1 (fast path).
- Grant rule, combinational, same cycle:
  - only one valid: grant it;
  - both valid: grant rr_ptr.
- req*_ready is asserted only for the granted requester, and only while a grant is possible. It is never asserted in EXEC or in a stalled RESP.
- On a grant edge:
  - the granted requester's operands load into the alu_* registers;
  - owner id is captured;
  - rr_ptr <= ~granted id;
  - state <= EXEC.
- A requester may drop valid before it is granted. Nothing is recorded and rr_ptr does not change.
- EXEC, exactly 1 cycle:
  - alu_* stay stable from the registers for the whole cycle;
  - at the edge: rsp_c <= alu_c, rsp_zero <= alu_zero, rsp_id <= owner, rsp_valid <= 1, state <= RESP.
- RESP:
  - rsp_* hold stable while rsp_ready=0;
  - rsp_ready=1 and no grant: rsp_valid <= 0, state <= IDLE;
  - rsp_ready=1 and a grant: rsp_valid <= 0, state <= EXEC with the new operands (rsp_valid rises again one cycle later).
- alu_* hold their last values outside EXEC. They change only on a grant edge.
- Latency and throughput:
  - accept edge N, rsp_valid high after edge N+1;
  - sustained throughput 1 op per 2 cycles with rsp_ready tied to 1.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- No arithmetic is done here. Result width and meaning are exactly as the ALU returns them.

Test Plan:
- Reset held low mid-EXEC, then released -> rsp_valid=0, all alu_* = 0, the next simultaneous request is granted to requester 0.
- req0 alone: a=5, b=3, op=add, rsp_ready=1 -> req0_ready high in the accept cycle; one cycle later rsp_valid=1, rsp_id=0, rsp_c=8, rsp_zero=0.
- req0 and req1 continuously valid, rsp_ready=1, 6 ops -> rsp_id sequence 0,1,0,1,0,1; one response every 2 cycles.
- req1: a=b=0x1234, op=sub; hold rsp_ready=0 for 4 cycles -> rsp_c=0, rsp_zero=1, rsp_id=1 stable all 4 cycles; req0_ready stays 0 although req0_valid=1.
- req0_valid pulses 1 cycle while state=EXEC, then drops -> no grant, no response for it, rr_ptr unchanged.
- RESP with rsp_ready=1 and req1 valid (op=lui, b=0x0001) -> same-edge handoff to EXEC; next response rsp_c=0x00010000, rsp_id=1, no IDLE cycle in between.
